mc_req_arbiter: RTL and testbench
=================================

Name: mc_req_arbiter

Overview:
- Two-requester arbiter that shares the single MC-side request interface of the AXI-Lite master IF between two masters, M0 and M1.
- Write and read channels are arbitrated independently, so one write and one read can be in flight at once.
- Sits between test/user masters and the AXI master IF; ports toward that IF keep the MC_* names and handshakes.

Parameters:
ADDR_WIDTH, 32, address width of all MC-side ports
DATA_WIDTH, 32, data width of all MC-side ports

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
M0_WREQ / M1_WREQ  input  1  write request; held high until own BACK
M0_WADDR / M1_WADDR  input  ADDR_WIDTH  write address; stable while WREQ high
M0_WDATA / M1_WDATA  input  DATA_WIDTH  write data; stable while WREQ high
M0_WACK / M1_WACK  output  1  write data accepted (pulse), granted requester only
M0_BACK / M1_BACK  output  1  write response done (pulse), granted requester only
M0_WERROR / M1_WERROR  output  1  write error; valid with BACK
M0_RREQ / M1_RREQ  input  1  read request; held high until own RACK
M0_RADDR / M1_RADDR  input  ADDR_WIDTH  read address; stable while RREQ high
M0_RACK / M1_RACK  output  1  read done (pulse), granted requester only
M0_RDATA / M1_RDATA  output  DATA_WIDTH  read data, broadcast; valid with RACK only
M0_RERROR / M1_RERROR  output  1  read error; valid with RACK
MC_WREQ, MC_WADDR, MC_WDATA  output  1/ADDR_WIDTH/DATA_WIDTH  to master IF
MC_WACK, MC_BACK, MC_WERROR  input  1 each  from master IF
MC_RREQ, MC_RADDR  output  1/ADDR_WIDTH  to master IF
MC_RACK, MC_RDATA, MC_RERROR  input  1/DATA_WIDTH/1  from master IF

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset:
  - All outputs 0; both channel FSMs go to IDLE.
  - Round-robin pointers point at M0 (M0 preferred first).
  - Reset mid-transaction drops the grant at once; MC_WREQ/MC_RREQ go low asynchronously.
- Channel FSM (write and read are identical, separate instances): IDLE, BUSY, RELEASE.
  - IDLE: if any REQ is high, register the grant and go to BUSY. Both high: grant the pointer's requester. One high: grant it.
  - BUSY:
    - MC_xREQ = 1; MC address/data are muxed from the registered grant.
    - MC_WACK/MC_BACK/MC_RACK and the error flags route combinationally to the granted requester only; the other requester sees 0.
    - On MC_BACK (write) or MC_RACK (read): go to RELEASE and set the pointer to the other requester.
  - RELEASE: MC_xREQ = 0 for exactly one cycle; grant cleared. Then arbitrate as in IDLE (to BUSY if any REQ, else IDLE).
- Latency:
  - Request first seen high in cycle N: MC_xREQ high in N+1.
  - Completion pulse in cycle K: MC_xREQ low in K+1; next grant drives MC_xREQ in K+2.
- Requester rules:
  - A requester must drop REQ in the cycle after its BACK/RACK.
  - REQ dropped while granted is ignored: the grant holds until the completion pulse, and that pulse is still delivered.
- Completion pulse while IDLE or RELEASE: discarded; no output asserted.
- Write and read FSMs never interact. Simultaneous completion pulses on both channels are each handled normally.
- Fairness: with both requesters continuously requesting, grants strictly alternate M0, M1, M0, ...

Optional Feature:
- Macro: MC_ARB_FIXED_PRIO_EN.
- Defined: pointer logic removed; M0 always wins when both request, and M1 may starve.
- Undefined (default): round-robin as above.
- Latency, RELEASE gap and routing are identical in both builds.

Decomposition:
- Shared package: FSM state encoding (ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RELEASE=2'd2) and the requester-index constants (REQ_M0=1'b0, REQ_M1=1'b1).
- One sub-module is natural: mc_arb_channel.
  - Contains one FSM plus pointer, parameterised by payload width.
  - Instantiated twice: write channel with payload ADDR_WIDTH+DATA_WIDTH, read channel with payload ADDR_WIDTH.
  - The top level only wires and routes return signals.

Test Plan:
- Single write: M0_WREQ=1, WADDR=0x2000_0010, WDATA=0xA5A5_0001 → MC_WREQ high next cycle with the same addr/data; MC_BACK routed to M0_BACK; M1_BACK stays 0.
- Contention: M0_WREQ and M1_WREQ both rise in the same cycle, held 4 transactions each → grant order M0, M1, M0, M1, with one-cycle MC_WREQ low gap between each.
- Concurrent channels: M0 writes 0x2000_0004 while M1 reads 0x2000_0008 → both MC_WREQ and MC_RREQ high together; M1_RDATA equals MC_RDATA at M1_RACK; M0 sees no RACK.
- Error path: slave returns MC_RERROR=1 with MC_RACK for M1's read → M1_RERROR=1 for that cycle only; M0_RERROR=0.
- Reset mid-transaction: assert rst_n=0 while write BUSY → MC_WREQ=0 immediately; after release the pointer is at M0 and a fresh M0 request is granted in 1 cycle.
- MC_ARB_FIXED_PRIO_EN build: both requesters held high for 3 transactions → all 3 grants to M0; M1 is granted only after M0_WREQ drops.

Source files
------------

// File: rtl/mc_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mc_req_arbiter_pkg
// Shared definitions for the two-requester MC request arbiter:
//   - arb_state_e : channel FSM state encoding (IDLE / BUSY / RELEASE)
//   - REQ_M0/M1   : requester index constants used for grants and pointers
//   - arb_pick    : grant selection helper (preferred requester on contention)
// -----------------------------------------------------------------------------
package mc_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // Picks the requester to grant. When both request, 'pref' decides;
    // a lone requester always wins.
    function automatic logic arb_pick(input logic req0, input logic req1, input logic pref);
        logic pick;
        if (req0 && req1) begin
            pick = pref;
        end else if (req1) begin
            pick = REQ_M1;
        end else begin
            pick = REQ_M0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mc_arb_channel.sv
// -----------------------------------------------------------------------------
// mc_arb_channel
// One arbitration channel (used once for writes, once for reads).
// FSM IDLE -> BUSY -> RELEASE with a round-robin pointer. The grant is
// registered; the MC-side request and payload are decoded from it.
//
// Configuration macro: MC_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin, pointer flips to the other requester
//                         after every completion
//   defined             : no pointer, M0 always wins on contention
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req0, req1     requests from M0 / M1
//   pay0, pay1     request payloads from M0 / M1 (PAY_WIDTH bits)
//   done           completion pulse from the MC side (BACK or RACK)
//   mc_req         request toward the master IF (high in BUSY only)
//   mc_pay         payload of the granted requester (zero when not BUSY)
//   grant          registered grant index (REQ_M0 / REQ_M1)
//   busy           channel is in BUSY; qualifies return routing
// -----------------------------------------------------------------------------
module mc_arb_channel
    import mc_req_arbiter_pkg::*;
#(
    parameter int PAY_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [PAY_WIDTH-1:0] pay0,
    input  logic [PAY_WIDTH-1:0] pay1,
    input  logic                 done,
    output logic                 mc_req,
    output logic [PAY_WIDTH-1:0] mc_pay,
    output logic                 grant,
    output logic                 busy
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       grant_r;
    logic       grant_nxt_s;
    logic       pick_s;

`ifdef MC_ARB_FIXED_PRIO_EN
    // Fixed priority: M0 is always preferred on contention.
    assign pick_s = arb_pick(req0, req1, REQ_M0);

    // State and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            grant_r <= REQ_M0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end
`else
    logic ptr_r;
    logic ptr_nxt_s;

    // Round-robin: the pointer names the requester preferred next time.
    assign pick_s = arb_pick(req0, req1, ptr_r);

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            grant_r <= REQ_M0;
            ptr_r   <= REQ_M0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Pointer update: after a completion, prefer the requester not just served.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if ((state_r == ARB_BUSY) && done) begin
            ptr_nxt_s = ~grant_r;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end
`endif

    // Next-state and next-grant logic. RELEASE arbitrates exactly like IDLE,
    // so back-to-back grants leave a single-cycle gap on mc_req.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ARB_IDLE, ARB_RELEASE: begin
                if (req0 || req1) begin
                    state_nxt_s = ARB_BUSY;
                    grant_nxt_s = pick_s;
                end else begin
                    state_nxt_s = ARB_IDLE;
                    grant_nxt_s = REQ_M0;
                end
            end
            ARB_BUSY: begin
                // A dropped request does not release the grant; only done does.
                if (done) begin
                    state_nxt_s = ARB_RELEASE;
                    grant_nxt_s = REQ_M0;
                end else begin
                    state_nxt_s = ARB_BUSY;
                    grant_nxt_s = grant_r;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                grant_nxt_s = REQ_M0;
            end
        endcase
    end

    assign busy   = (state_r == ARB_BUSY);
    assign mc_req = busy;
    assign grant  = grant_r;
    // Payload is forced to zero outside BUSY so reset leaves the MC side quiet.
    assign mc_pay = busy ? ((grant_r == REQ_M1) ? pay1 : pay0) : {PAY_WIDTH{1'b0}};

endmodule

// File: rtl/mc_req_arbiter.sv
// -----------------------------------------------------------------------------
// mc_req_arbiter
// Shares the single MC-side request interface of the AXI-Lite master IF
// between two masters (M0, M1). Write and read channels are arbitrated by two
// independent mc_arb_channel instances, so one write and one read can be in
// flight together. Return handshakes and error flags are routed only to the
// requester currently granted on that channel; read data is broadcast while
// a read completion is being delivered.
//
// Configuration macro: MC_ARB_FIXED_PRIO_EN (fixed M0 priority when defined,
// round-robin otherwise).
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   Mx_WREQ/WADDR/WDATA   (in)         write request + payload from master x
//   Mx_WACK/BACK/WERROR   (out)        write handshakes to master x
//   Mx_RREQ/RADDR         (in)         read request + address from master x
//   Mx_RACK/RDATA/RERROR  (out)        read completion to master x
//   MC_WREQ/WADDR/WDATA   (out)        write request toward master IF
//   MC_WACK/BACK/WERROR   (in)         write handshakes from master IF
//   MC_RREQ/RADDR         (out)        read request toward master IF
//   MC_RACK/RDATA/RERROR  (in)         read completion from master IF
// -----------------------------------------------------------------------------
module mc_req_arbiter
    import mc_req_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  M0_WREQ,
    input  logic [ADDR_WIDTH-1:0] M0_WADDR,
    input  logic [DATA_WIDTH-1:0] M0_WDATA,
    output logic                  M0_WACK,
    output logic                  M0_BACK,
    output logic                  M0_WERROR,
    input  logic                  M1_WREQ,
    input  logic [ADDR_WIDTH-1:0] M1_WADDR,
    input  logic [DATA_WIDTH-1:0] M1_WDATA,
    output logic                  M1_WACK,
    output logic                  M1_BACK,
    output logic                  M1_WERROR,
    input  logic                  M0_RREQ,
    input  logic [ADDR_WIDTH-1:0] M0_RADDR,
    output logic                  M0_RACK,
    output logic [DATA_WIDTH-1:0] M0_RDATA,
    output logic                  M0_RERROR,
    input  logic                  M1_RREQ,
    input  logic [ADDR_WIDTH-1:0] M1_RADDR,
    output logic                  M1_RACK,
    output logic [DATA_WIDTH-1:0] M1_RDATA,
    output logic                  M1_RERROR,
    output logic                  MC_WREQ,
    output logic [ADDR_WIDTH-1:0] MC_WADDR,
    output logic [DATA_WIDTH-1:0] MC_WDATA,
    input  logic                  MC_WACK,
    input  logic                  MC_BACK,
    input  logic                  MC_WERROR,
    output logic                  MC_RREQ,
    output logic [ADDR_WIDTH-1:0] MC_RADDR,
    input  logic                  MC_RACK,
    input  logic [DATA_WIDTH-1:0] MC_RDATA,
    input  logic                  MC_RERROR
);

    localparam int WPAY_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    logic                  w_grant_s;
    logic                  w_busy_s;
    logic [WPAY_WIDTH-1:0] w_pay_s;
    logic                  r_grant_s;
    logic                  r_busy_s;
    logic                  w_sel0_s;
    logic                  w_sel1_s;
    logic                  r_sel0_s;
    logic                  r_sel1_s;

    mc_arb_channel #(
        .PAY_WIDTH (WPAY_WIDTH)
    ) u_wr_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (M0_WREQ),
        .req1   (M1_WREQ),
        .pay0   ({M0_WADDR, M0_WDATA}),
        .pay1   ({M1_WADDR, M1_WDATA}),
        .done   (MC_BACK),
        .mc_req (MC_WREQ),
        .mc_pay (w_pay_s),
        .grant  (w_grant_s),
        .busy   (w_busy_s)
    );

    mc_arb_channel #(
        .PAY_WIDTH (ADDR_WIDTH)
    ) u_rd_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (M0_RREQ),
        .req1   (M1_RREQ),
        .pay0   (M0_RADDR),
        .pay1   (M1_RADDR),
        .done   (MC_RACK),
        .mc_req (MC_RREQ),
        .mc_pay (MC_RADDR),
        .grant  (r_grant_s),
        .busy   (r_busy_s)
    );

    assign {MC_WADDR, MC_WDATA} = w_pay_s;

    // Return routing is qualified by BUSY, so pulses arriving in IDLE or
    // RELEASE are dropped without reaching either requester.
    assign w_sel0_s = w_busy_s && (w_grant_s == REQ_M0);
    assign w_sel1_s = w_busy_s && (w_grant_s == REQ_M1);
    assign r_sel0_s = r_busy_s && (r_grant_s == REQ_M0);
    assign r_sel1_s = r_busy_s && (r_grant_s == REQ_M1);

    assign M0_WACK   = w_sel0_s && MC_WACK;
    assign M1_WACK   = w_sel1_s && MC_WACK;
    assign M0_BACK   = w_sel0_s && MC_BACK;
    assign M1_BACK   = w_sel1_s && MC_BACK;
    assign M0_WERROR = w_sel0_s && MC_BACK && MC_WERROR;
    assign M1_WERROR = w_sel1_s && MC_BACK && MC_WERROR;

    assign M0_RACK   = r_sel0_s && MC_RACK;
    assign M1_RACK   = r_sel1_s && MC_RACK;
    assign M0_RERROR = r_sel0_s && MC_RACK && MC_RERROR;
    assign M1_RERROR = r_sel1_s && MC_RACK && MC_RERROR;

    // Read data is shared by both requesters but only driven during a
    // delivered completion; each requester qualifies it with its own RACK.
    assign M0_RDATA = (r_busy_s && MC_RACK) ? MC_RDATA : {DATA_WIDTH{1'b0}};
    assign M1_RDATA = (r_busy_s && MC_RACK) ? MC_RDATA : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mc_req_arbiter.sv
module tb_mc_req_arbiter;

    typedef struct packed {
        logic        idx;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        M0_WREQ = 1'b0, M1_WREQ = 1'b0;
    logic [31:0] M0_WADDR = 32'h0, M1_WADDR = 32'h0;
    logic [31:0] M0_WDATA = 32'h0, M1_WDATA = 32'h0;
    logic        M0_WACK, M1_WACK, M0_BACK, M1_BACK, M0_WERROR, M1_WERROR;
    logic        M0_RREQ = 1'b0, M1_RREQ = 1'b0;
    logic [31:0] M0_RADDR = 32'h0, M1_RADDR = 32'h0;
    logic        M0_RACK, M1_RACK, M0_RERROR, M1_RERROR;
    logic [31:0] M0_RDATA, M1_RDATA;
    logic        MC_WREQ, MC_RREQ;
    logic [31:0] MC_WADDR, MC_WDATA, MC_RADDR;
    logic        MC_WACK = 1'b0, MC_BACK = 1'b0, MC_WERROR = 1'b0;
    logic        MC_RACK = 1'b0, MC_RERROR = 1'b0;
    logic [31:0] MC_RDATA = 32'h0;

    int   total = 0;
    int   bad   = 0;
    exp_t wq[$];
    exp_t rq[$];

    mc_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .M0_WREQ(M0_WREQ), .M0_WADDR(M0_WADDR), .M0_WDATA(M0_WDATA),
        .M0_WACK(M0_WACK), .M0_BACK(M0_BACK), .M0_WERROR(M0_WERROR),
        .M1_WREQ(M1_WREQ), .M1_WADDR(M1_WADDR), .M1_WDATA(M1_WDATA),
        .M1_WACK(M1_WACK), .M1_BACK(M1_BACK), .M1_WERROR(M1_WERROR),
        .M0_RREQ(M0_RREQ), .M0_RADDR(M0_RADDR), .M0_RACK(M0_RACK),
        .M0_RDATA(M0_RDATA), .M0_RERROR(M0_RERROR),
        .M1_RREQ(M1_RREQ), .M1_RADDR(M1_RADDR), .M1_RACK(M1_RACK),
        .M1_RDATA(M1_RDATA), .M1_RERROR(M1_RERROR),
        .MC_WREQ(MC_WREQ), .MC_WADDR(MC_WADDR), .MC_WDATA(MC_WDATA),
        .MC_WACK(MC_WACK), .MC_BACK(MC_BACK), .MC_WERROR(MC_WERROR),
        .MC_RREQ(MC_RREQ), .MC_RADDR(MC_RADDR),
        .MC_RACK(MC_RACK), .MC_RDATA(MC_RDATA), .MC_RERROR(MC_RERROR)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_wreq();
        int n = 0;
        while (MC_WREQ !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk1("wreq_seen", MC_WREQ, 1'b1);
    endtask

    function automatic exp_t mk(input logic idx, input int cnt);
        exp_t e;
        e.idx  = idx;
        e.addr = 32'h3000_0000 | (32'(idx) << 8) | 32'(cnt);
        e.data = 32'hC0DE_0000 | (32'(idx) << 12) | 32'(cnt);
        return e;
    endfunction

    task automatic raise_w(input exp_t e);
        if (e.idx) begin
            M1_WREQ = 1'b1; M1_WADDR = e.addr; M1_WDATA = e.data;
        end else begin
            M0_WREQ = 1'b1; M0_WADDR = e.addr; M0_WDATA = e.data;
        end
        wq.push_back(e);
    endtask

    // Serves the oldest expected write: compares payload, delivers WACK and
    // BACK, and returns in the following (gap) cycle.
    task automatic serve_write(input logic hold, output logic idx);
        exp_t x;
        x = '0;
        wait_wreq();
        if (wq.size() > 0) x = wq.pop_front();
        idx = x.idx;
        chk32("waddr", MC_WADDR, x.addr);
        chk32("wdata", MC_WDATA, x.data);
        MC_WACK = 1'b1;
        #1;
        chk1("wack_own", x.idx ? M1_WACK : M0_WACK, 1'b1);
        chk1("wack_other", x.idx ? M0_WACK : M1_WACK, 1'b0);
        tick();
        MC_WACK = 1'b0;
        MC_BACK = 1'b1;
        #1;
        chk1("back_own", x.idx ? M1_BACK : M0_BACK, 1'b1);
        chk1("back_other", x.idx ? M0_BACK : M1_BACK, 1'b0);
        tick();
        MC_BACK = 1'b0;
        if (!hold) begin
            if (x.idx) M1_WREQ = 1'b0; else M0_WREQ = 1'b0;
        end
        #1;
        chk1("wreq_gap", MC_WREQ, 1'b0);
    endtask

    initial begin
        logic g;
        exp_t e;
        exp_t a0;
        exp_t a1;
        int   c0;
        int   c1;

        // Reset state
        #1;
        chk1("rst_wreq", MC_WREQ, 1'b0);
        chk1("rst_rreq", MC_RREQ, 1'b0);
        chk32("rst_waddr", MC_WADDR, 32'h0);
        chk1("rst_m0_wack", M0_WACK, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single write from M0
        e.idx = 1'b0; e.addr = 32'h2000_0010; e.data = 32'hA5A5_0001;
        raise_w(e);
        #1;
        chk1("single_lat_n", MC_WREQ, 1'b0);
        tick();
        chk1("single_lat_n1", MC_WREQ, 1'b1);
        serve_write(1'b0, g);
        tick();

        // M1 drops its request while granted: grant and BACK still delivered
        e.idx = 1'b1; e.addr = 32'h2000_0020; e.data = 32'h5A5A_0002;
        raise_w(e);
        tick();
        chk1("drop_granted", MC_WREQ, 1'b1);
        M1_WREQ = 1'b0;
        tick();
        chk1("drop_held", MC_WREQ, 1'b1);
        serve_write(1'b0, g);
        tick();

`ifdef MC_ARB_FIXED_PRIO_EN
        // Fixed priority: M0 held high wins three times, M1 waits
        a0 = mk(1'b0, 0);
        a1 = mk(1'b1, 0);
        M1_WREQ = 1'b1; M1_WADDR = a1.addr; M1_WDATA = a1.data;
        raise_w(a0);
        wq.push_back(a0);
        wq.push_back(a0);
        for (int t = 0; t < 3; t++) begin
            serve_write(1'b1, g);
        end
        M0_WREQ = 1'b0;
        wq.push_back(a1);
        serve_write(1'b0, g);
        tick();
`else
        // Contention: both request continuously, four transactions each
        c0 = 1;
        c1 = 1;
        raise_w(mk(1'b0, 0));
        raise_w(mk(1'b1, 0));
        for (int t = 0; t < 8; t++) begin
            serve_write(1'b0, g);
            tick();
            if (t < 7) chk1("rr_next_grant", MC_WREQ, 1'b1);
            if (g == 1'b0 && c0 < 4) begin
                raise_w(mk(1'b0, c0));
                c0++;
            end else if (g == 1'b1 && c1 < 4) begin
                raise_w(mk(1'b1, c1));
                c1++;
            end
        end
        tick();
`endif

        // Concurrent channels: M0 write with M1 read, simultaneous completions
        e.idx = 1'b0; e.addr = 32'h2000_0004; e.data = 32'h1111_2222;
        raise_w(e);
        e.idx = 1'b1; e.addr = 32'h2000_0008; e.data = 32'h0;
        M1_RREQ = 1'b1; M1_RADDR = e.addr;
        rq.push_back(e);
        tick();
        chk1("conc_wreq", MC_WREQ, 1'b1);
        chk1("conc_rreq", MC_RREQ, 1'b1);
        e = wq.pop_front();
        chk32("conc_waddr", MC_WADDR, e.addr);
        e = rq.pop_front();
        chk32("conc_raddr", MC_RADDR, e.addr);
        MC_BACK = 1'b1; MC_RACK = 1'b1; MC_RDATA = 32'hDEAD_BEEF;
        #1;
        chk1("conc_m0_back", M0_BACK, 1'b1);
        chk1("conc_m1_back", M1_BACK, 1'b0);
        chk1("conc_m1_rack", M1_RACK, 1'b1);
        chk1("conc_m0_rack", M0_RACK, 1'b0);
        chk32("conc_m1_rdata", M1_RDATA, 32'hDEAD_BEEF);
        tick();
        MC_BACK = 1'b0; MC_RACK = 1'b0; MC_RDATA = 32'h0;
        M0_WREQ = 1'b0; M1_RREQ = 1'b0;
        #1;
        chk1("conc_wgap", MC_WREQ, 1'b0);
        chk1("conc_rgap", MC_RREQ, 1'b0);
        tick();

        // Read error for M1; a repeated pulse in RELEASE is discarded
        M1_RREQ = 1'b1; M1_RADDR = 32'h2000_000C;
        tick();
        chk32("err_raddr", MC_RADDR, 32'h2000_000C);
        MC_RACK = 1'b1; MC_RERROR = 1'b1; MC_RDATA = 32'h0BAD_0BAD;
        #1;
        chk1("err_m1_rerror", M1_RERROR, 1'b1);
        chk1("err_m0_rerror", M0_RERROR, 1'b0);
        chk1("err_m1_rack", M1_RACK, 1'b1);
        tick();
        M1_RREQ = 1'b0;
        #1;
        chk1("err_release_rerror", M1_RERROR, 1'b0);
        chk1("err_release_rack", M1_RACK, 1'b0);
        tick();
        MC_RACK = 1'b0; MC_RERROR = 1'b0; MC_RDATA = 32'h0;

        // Stray write completion while IDLE is discarded
        MC_BACK = 1'b1; MC_WERROR = 1'b1;
        #1;
        chk1("idle_m0_back", M0_BACK, 1'b0);
        chk1("idle_m1_back", M1_BACK, 1'b0);
        chk1("idle_m0_werror", M0_WERROR, 1'b0);
        tick();
        MC_BACK = 1'b0; MC_WERROR = 1'b0;
        chk1("idle_stays", MC_WREQ, 1'b0);

        // Both request with pointer at M1, then reset mid-transaction
        a0 = mk(1'b0, 9);
        a1 = mk(1'b1, 9);
        M0_WREQ = 1'b1; M0_WADDR = a0.addr; M0_WDATA = a0.data;
        M1_WREQ = 1'b1; M1_WADDR = a1.addr; M1_WDATA = a1.data;
        tick();
        chk1("pre_rst_wreq", MC_WREQ, 1'b1);
`ifdef MC_ARB_FIXED_PRIO_EN
        chk32("pre_rst_grant", MC_WADDR, a0.addr);
`else
        chk32("pre_rst_grant", MC_WADDR, a1.addr);
`endif
        tick();
        rst_n = 1'b0;
        #1;
        chk1("rst_async_wreq", MC_WREQ, 1'b0);
        chk32("rst_async_waddr", MC_WADDR, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk1("post_rst_wreq", MC_WREQ, 1'b1);
        chk32("post_rst_grant", MC_WADDR, a0.addr);
        wq.push_back(a0);
        serve_write(1'b0, g);
        wq.push_back(a1);
        tick();
        serve_write(1'b0, g);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
